// File: rtl/apb_slave_regbank_pkg.sv
// apb_pkg: shared types and helpers for the APB completer register bank.
//   - apb_state_e : setup/access FSM states
//   - OFF_*       : word offsets (Paddr[5:2]) of the fixed registers
//   - REG_SPACE   : number of word slots addressable through Paddr[5:2]
//   - addr_error  : decode of every condition that yields Pslverr
package apb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam logic [3:0] OFF_ID       = 4'd0;
    localparam logic [3:0] OFF_CTRL     = 4'd1;
    localparam logic [3:0] OFF_STATUS   = 4'd2;
    localparam logic [3:0] OFF_SCRATCH0 = 4'd3;

    localparam int REG_SPACE = 16;

    // Misaligned, outside the 64-byte window, beyond the implemented
    // registers, or a write to one of the read-only registers.
    function automatic logic addr_error(input logic [31:0] paddr,
                                        input logic        pwrite,
                                        input int          num_regs);
        logic [3:0] off;
        logic       err;
        off = paddr[5:2];
        err = 1'b0;
        if (paddr[1:0] != 2'b00)
            err = 1'b1;
        if (|paddr[31:6])
            err = 1'b1;
        if (int'(off) >= num_regs)
            err = 1'b1;
        if (pwrite && ((off == OFF_ID) || (off == OFF_STATUS)))
            err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the bridge (master) and a completer (slave).
//   Pselx[2:0]  one-hot select          Penable  access-phase strobe
//   Pwrite      1 = write               Paddr    byte address
//   Pwdata      write data              Prdata   read data
//   Pready      transfer completes      Pslverr  error response
interface apb_slave_regbank_if;

    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        output Pselx, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Pselx, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );

endinterface

// File: rtl/apb_slave_regbank_fsm.sv
// apb_slave_fsm: APB setup/access sequencing with a wait-state down-counter.
//   clk, rst  : clock, async active-high reset
//   sel       : this completer's select bit
//   penable   : APB access strobe
//   setup     : setup cycle accepted (state goes IDLE -> ACCESS this edge)
//   complete  : completion edge of a legal access
//   abort     : select or enable dropped during access
//   ready     : registered Pready (ACCESS with the counter at terminal count)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transfer; waiting for sel & !penable
// ST_ACCESS | access phase; cnt counts down wait states, ready at cnt == 0
module apb_slave_fsm
    import apb_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic sel,
    input  logic penable,
    output logic setup,
    output logic complete,
    output logic abort,
    output logic ready
);

    apb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ready depends on registered state only, so Pready has no
    // combinational path from the bus inputs.
    assign ready = (state_q == ST_ACCESS) && (cnt_q == 4'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        setup    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // penable without a preceding setup cycle is ignored
                if (sel && !penable) begin
                    setup   = 1'b1;
                    state_d = ST_ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            ST_ACCESS: begin
                if (!(sel && penable)) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd0) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB completer serving a small word register bank.
//   Hclk, Hreset : clock, async active-high reset
//   bus          : APB slave modport (Pselx/Penable/Pwrite/Paddr/Pwdata in,
//                  Prdata/Pready/Pslverr out)
// Register map (word offset Paddr[5:2]):
//   0 ID (RO, ID_VALUE), 1 CTRL (RW), 2 STATUS (RO {wr_count, err_count}),
//   3 .. NUM_REGS-1 SCRATCH (RW)
module apb_slave_regbank
    import apb_pkg::*;
#(
    parameter int          SEL_INDEX   = 0,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic                 Hclk,
    input  logic                 Hreset,
    apb_slave_regbank_if.slave   bus
);

    logic sel;
    logic setup, complete, abort, ready;

    assign sel = bus.Pselx[SEL_INDEX];

    apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
        .clk      (Hclk),
        .rst      (Hreset),
        .sel      (sel),
        .penable  (bus.Penable),
        .setup    (setup),
        .complete (complete),
        .abort    (abort),
        .ready    (ready)
    );

    // Full 16-slot array keeps the offset index width exact; slots that are
    // read-only or beyond NUM_REGS are never written and stay 0.
    logic [31:0] regs_q [REG_SPACE];
    logic [31:0] regs_d [REG_SPACE];
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] err_count_q, err_count_d;

    // Transfer attributes captured at setup
    logic        err_q, err_d;
    logic        wr_q, wr_d;
    logic [3:0]  off_q, off_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  off_now;
    logic        err_now;
    logic [31:0] rd_val;

    assign off_now = bus.Paddr[5:2];
    assign err_now = addr_error(bus.Paddr, bus.Pwrite, NUM_REGS);

    always_comb begin
        rd_val = '0;
        case (off_now)
            OFF_ID:     rd_val = ID_VALUE;
            OFF_STATUS: rd_val = {wr_count_q, err_count_q};
            default:    rd_val = regs_q[off_now];
        endcase
    end

    always_comb begin
        err_d       = err_q;
        wr_d        = wr_q;
        off_d       = off_q;
        rdata_d     = rdata_q;
        regs_d      = regs_q;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;

        if (setup) begin
            err_d   = err_now;
            wr_d    = bus.Pwrite;
            off_d   = off_now;
            // Read data is frozen here, so a same-cycle counter bump or
            // write completion is not visible to this read.
            rdata_d = (!bus.Pwrite && !err_now) ? rd_val : 32'h0;
        end

        if (abort) begin
            err_d   = 1'b0;
            rdata_d = 32'h0;
        end

        if (complete) begin
            if (err_q) begin
                if (err_count_q != 16'hFFFF)
                    err_count_d = err_count_q + 16'd1;
            end else if (wr_q) begin
                regs_d[off_q] = bus.Pwdata;
                if (wr_count_q != 16'hFFFF)
                    wr_count_d = wr_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            off_q       <= 4'd0;
            rdata_q     <= 32'h0;
            wr_count_q  <= 16'h0;
            err_count_q <= 16'h0;
            for (int i = 0; i < REG_SPACE; i++)
                regs_q[i] <= 32'h0;
        end else begin
            err_q       <= err_d;
            wr_q        <= wr_d;
            off_q       <= off_d;
            rdata_q     <= rdata_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
            regs_q      <= regs_d;
        end
    end

    assign bus.Pready  = ready;
    assign bus.Prdata  = ready ? rdata_q : 32'h0;
    assign bus.Pslverr = ready & err_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench: three completers (WAIT_STATES 0, 3, 2) on separate buses;
// the shared stimulus is routed to one of them at a time.
module tb_apb_slave_regbank;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic [2:0]  pselx;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    int          which;
    int          n_assert = 0;
    int          n_fail   = 0;

    logic        obs_ready, obs_err;
    logic [31:0] obs_rdata;

    logic [31:0] rd;
    logic        er;
    int          cyc;
    logic        any_ready;

    always #5 Hclk = ~Hclk;

    apb_slave_regbank_if bus0 ();
    apb_slave_regbank_if bus1 ();
    apb_slave_regbank_if bus2 ();

    assign bus0.Pselx = (which == 0) ? pselx : 3'b000;
    assign bus1.Pselx = (which == 1) ? pselx : 3'b000;
    assign bus2.Pselx = (which == 2) ? pselx : 3'b000;
    assign bus0.Penable = penable;  assign bus1.Penable = penable;  assign bus2.Penable = penable;
    assign bus0.Pwrite  = pwrite;   assign bus1.Pwrite  = pwrite;   assign bus2.Pwrite  = pwrite;
    assign bus0.Paddr   = paddr;    assign bus1.Paddr   = paddr;    assign bus2.Paddr   = paddr;
    assign bus0.Pwdata  = pwdata;   assign bus1.Pwdata  = pwdata;   assign bus2.Pwdata  = pwdata;

    apb_slave_regbank #(.WAIT_STATES(0)) dut0 (.Hclk(Hclk), .Hreset(Hreset), .bus(bus0));
    apb_slave_regbank #(.WAIT_STATES(3)) dut1 (.Hclk(Hclk), .Hreset(Hreset), .bus(bus1));
    apb_slave_regbank #(.WAIT_STATES(2)) dut2 (.Hclk(Hclk), .Hreset(Hreset), .bus(bus2));

    always_comb begin
        obs_ready = bus0.Pready;
        obs_err   = bus0.Pslverr;
        obs_rdata = bus0.Prdata;
        if (which == 1) begin
            obs_ready = bus1.Pready;
            obs_err   = bus1.Pslverr;
            obs_rdata = bus1.Prdata;
        end else if (which == 2) begin
            obs_ready = bus2.Pready;
            obs_err   = bus2.Pslverr;
            obs_rdata = bus2.Prdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transfer; cyc = access cycle in which Pready was seen.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdat, output logic err, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        rdat   = 32'h0;
        err    = 1'b0;
        @(posedge Hclk); #1;
        pselx = 3'b001; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge Hclk); #1;
        penable = 1'b1;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (obs_ready) begin
                seen   = 1'b1;
                cycles = i;
                rdat   = obs_rdata;
                err    = obs_err;
            end else begin
                @(posedge Hclk); #1;
            end
        end
        check("xfer_ready_seen", 32'(seen), 32'd1);
        @(posedge Hclk); #1;
        pselx = 3'b000; penable = 1'b0;
        check("ready_one_cycle", 32'(obs_ready), 32'd0);
    endtask

    task automatic watch_no_ready(input int n, output logic any);
        any = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge Hclk); #1;
            if (obs_ready) any = 1'b1;
        end
    endtask

    initial begin
        which = 0; Hreset = 1'b1;
        pselx = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        #12;
        check("rst_pready",  32'(obs_ready), 32'd0);
        check("rst_prdata",  obs_rdata,      32'h0);
        check("rst_pslverr", 32'(obs_err),   32'd0);
        @(posedge Hclk); #1; Hreset = 1'b0;

        // ---- WAIT_STATES = 0 ----
        xfer(1'b0, 32'h00, 32'h0, rd, er, cyc);
        check("id_latency", 32'(cyc), 32'd1);
        check("id_rdata",   rd,       32'hA5B0_0001);
        check("id_err",     32'(er),  32'd0);

        xfer(1'b1, 32'h0C, 32'hDEAD_BEEF, rd, er, cyc);
        check("wr_scratch_err",   32'(er), 32'd0);
        check("wr_scratch_rdata", rd,      32'h0);
        xfer(1'b0, 32'h0C, 32'h0, rd, er, cyc);
        check("rd_scratch", rd, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h08, 32'h0, rd, er, cyc);
        check("status_after_wr", rd, 32'h0001_0000);

        xfer(1'b1, 32'h00, 32'h1111_1111, rd, er, cyc);
        check("err_wr_id",       32'(er), 32'd1);
        check("err_wr_id_rdata", rd,      32'h0);
        xfer(1'b0, 32'h02, 32'h0, rd, er, cyc);
        check("err_misalign",       32'(er), 32'd1);
        check("err_misalign_rdata", rd,      32'h0);
        xfer(1'b0, 32'h40, 32'h0, rd, er, cyc);
        check("err_high_addr",       32'(er), 32'd1);
        check("err_high_addr_rdata", rd,      32'h0);
        xfer(1'b0, 32'h20, 32'h0, rd, er, cyc);
        check("err_beyond_regs", 32'(er), 32'd1);
        xfer(1'b0, 32'h08, 32'h0, rd, er, cyc);
        check("status_after_err", rd, 32'h0001_0004);
        check("status_err_flag",  32'(er), 32'd0);
        xfer(1'b0, 32'h00, 32'h0, rd, er, cyc);
        check("id_unchanged", rd, 32'hA5B0_0001);

        // select bit of another slave only
        @(posedge Hclk); #1;
        pselx = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
        @(posedge Hclk); #1; penable = 1'b1;
        watch_no_ready(4, any_ready);
        check("other_sel_no_ready", 32'(any_ready | obs_ready), 32'd0);
        pselx = 3'b000; penable = 1'b0;

        // penable without setup is ignored
        @(posedge Hclk); #1;
        pselx = 3'b001; penable = 1'b1;
        watch_no_ready(4, any_ready);
        check("enable_no_setup", 32'(any_ready), 32'd0);
        pselx = 3'b000; penable = 1'b0;

        // ---- WAIT_STATES = 3 ----
        which = 1;
        xfer(1'b0, 32'h04, 32'h0, rd, er, cyc);
        check("ctrl_before", rd, 32'h0);
        check("ws3_rd_latency", 32'(cyc), 32'd4);
        xfer(1'b1, 32'h04, 32'h0000_0005, rd, er, cyc);
        check("ws3_wr_latency", 32'(cyc), 32'd4);
        check("ws3_wr_err",     32'(er),  32'd0);
        xfer(1'b0, 32'h04, 32'h0, rd, er, cyc);
        check("ctrl_after", rd, 32'h0000_0005);

        // ---- WAIT_STATES = 2: abort mid-wait ----
        which = 2;
        @(posedge Hclk); #1;
        pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h1234_5678;
        @(posedge Hclk); #1; penable = 1'b1;
        check("abort_wait1_ready", 32'(obs_ready), 32'd0);
        @(posedge Hclk); #1;
        pselx = 3'b000; penable = 1'b0;
        watch_no_ready(5, any_ready);
        check("abort_no_ready", 32'(any_ready), 32'd0);
        xfer(1'b0, 32'h0C, 32'h0, rd, er, cyc);
        check("abort_no_write", rd, 32'h0);
        check("ws2_latency", 32'(cyc), 32'd3);
        xfer(1'b0, 32'h08, 32'h0, rd, er, cyc);
        check("abort_status", rd, 32'h0);

        // ---- reset during access of a write (WAIT_STATES = 0) ----
        which = 0;
        @(posedge Hclk); #1;
        pselx = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hCAFE_F00D;
        @(posedge Hclk); #1; penable = 1'b1;
        check("rst_mid_pre_ready", 32'(obs_ready), 32'd1);
        #2 Hreset = 1'b1;
        #1;
        check("rst_mid_ready", 32'(obs_ready), 32'd0);
        check("rst_mid_rdata", obs_rdata,      32'h0);
        check("rst_mid_err",   32'(obs_err),   32'd0);
        pselx = 3'b000; penable = 1'b0;
        @(posedge Hclk); #1; Hreset = 1'b0;
        xfer(1'b0, 32'h10, 32'h0, rd, er, cyc);
        check("rst_no_write", rd, 32'h0);
        xfer(1'b1, 32'h10, 32'h5A5A_5A5A, rd, er, cyc);
        check("post_rst_wr_err", 32'(er), 32'd0);
        xfer(1'b0, 32'h10, 32'h0, rd, er, cyc);
        check("post_rst_rd", rd, 32'h5A5A_5A5A);
        xfer(1'b0, 32'h08, 32'h0, rd, er, cyc);
        check("post_rst_status", rd, 32'h0001_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
